// File: rtl/cache_pkg.sv
// cache_pkg: shared fill-state type and default cache-fill geometry
package cache_pkg;
  typedef enum logic {IDLE, FILL} fill_state_e;
  localparam int WORD_BYTES = 2;
  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int DEF_ADDR_WIDTH = 16;
endpackage

// File: rtl/fill_counter.sv
// fill_counter: clearable, enabled counter saturating at MAX with terminal-count flag
module fill_counter #(
  parameter int MAX = 8,
  parameter int OW = $clog2(MAX),
  parameter int CW = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [OW-1:0] cnt,
  output logic          tc
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tc = cnt_q == CW'(MAX);
  assign cnt = cnt_q[OW-1:0];
  always_comb cnt_d = clr ? '0 : (en && !tc) ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: block fill engine for a multicycle memory; CRITICAL_WORD_FIRST_EN selects critical-word-first order
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LW = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  output logic                  fsm_busy,
  output logic                  memory_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data_out,
  output logic                  write_data_array,
  output logic [LW-1:0]         word_offset,
  output logic [15:0]           cache_data,
  output logic                  write_tag_array
);
  localparam int BW = $clog2(WORD_BYTES * WORDS_PER_BLOCK);
  localparam int WS = $clog2(WORD_BYTES);
  fill_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LW-1:0] iss_cnt, rx_cnt, iss_off, rx_off;
  logic iss_done, rx_done, start;
  assign start = state_q == IDLE && miss_detected;
  assign fsm_busy = state_q == FILL;
  assign memory_enable = fsm_busy && !iss_done;
  assign write_data_array = memory_data_valid && fsm_busy && !rx_done;
  assign write_tag_array = write_data_array && rx_cnt == LW'(WORDS_PER_BLOCK - 1);
  assign memory_address = memory_enable ? base_q + (ADDR_WIDTH'(iss_off) << WS) : '0;
  assign word_offset = rx_off;
  assign cache_data = memory_data_out;
`ifdef CRITICAL_WORD_FIRST_EN
  logic [LW-1:0] crit_q, crit_d;
  always_comb crit_d = start ? miss_address[BW-1 -: LW] : crit_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) crit_q <= '0;
    else crit_q <= crit_d;
  assign iss_off = crit_q + iss_cnt;
  assign rx_off = crit_q + rx_cnt;
`else
  assign iss_off = iss_cnt;
  assign rx_off = rx_cnt;
`endif
  always_comb begin
    base_d = start ? miss_address & ({ADDR_WIDTH{1'b1}} << BW) : base_q;
    state_d = state_q == IDLE ? (miss_detected ? FILL : IDLE) : (write_tag_array ? IDLE : FILL);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      base_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
    end
  fill_counter #(.MAX(WORDS_PER_BLOCK)) u_issue (
    .clk(clk), .rst(rst), .clr(start), .en(memory_enable), .cnt(iss_cnt), .tc(iss_done)
  );
  fill_counter #(.MAX(WORDS_PER_BLOCK)) u_recv (
    .clk(clk), .rst(rst), .clr(start), .en(write_data_array), .cnt(rx_cnt), .tc(rx_done)
  );
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: scoreboard bench with a 4-cycle memory model for cache_fill_fsm
module tb_cache_fill_fsm;
  localparam int W = 8;
  localparam int LW = 3;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  typedef struct {
    logic [LW-1:0] off;
    logic [15:0] data;
    logic tag;
  } wr_t;
  logic clk = 1'b0, rst = 1'b1;
  logic miss_detected = 1'b0, memory_data_valid = 1'b0;
  logic [15:0] miss_address = '0, memory_data_out = '0;
  logic fsm_busy, memory_enable, write_data_array, write_tag_array;
  logic [15:0] memory_address, cache_data;
  logic [LW-1:0] word_offset;
  logic mv[4];
  logic [15:0] ma[4];
  logic [15:0] exp_addr[$];
  wr_t exp_wr[$];
  int checks = 0, errors = 0, busy_cnt = 0, wr_seen = 0, wr_base = 0;
  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .fsm_busy(fsm_busy), .memory_enable(memory_enable), .memory_address(memory_address),
    .memory_data_valid(memory_data_valid), .memory_data_out(memory_data_out),
    .write_data_array(write_data_array), .word_offset(word_offset),
    .cache_data(cache_data), .write_tag_array(write_tag_array)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_exp(input logic [15:0] a);
    logic [15:0] base, addr;
    logic [LW-1:0] crit, off;
    base = a & 16'hFFF0;
    crit = a[LW:1];
    for (int i = 0; i < W; i++) begin
      off = CWF ? LW'(crit + LW'(i)) : LW'(i);
      addr = base + {12'h0, off, 1'b0};
      exp_addr.push_back(addr);
      exp_wr.push_back('{off: off, data: addr ^ 16'h5A5A, tag: i == W - 1});
    end
  endtask
  task automatic step(input logic miss, input logic [15:0] addr, input logic stray);
    wr_t w;
    @(negedge clk);
    miss_detected = miss;
    miss_address = addr;
    memory_data_valid = stray | mv[3];
    memory_data_out = stray ? 16'hBEEF : (mv[3] ? ma[3] ^ 16'h5A5A : 16'h0);
    #1;
    if (fsm_busy) busy_cnt++;
    if (memory_enable) begin
      if (exp_addr.size() == 0) chk("extra_issue", memory_enable, 0);
      else chk("issue_addr", memory_address, exp_addr.pop_front());
    end
    if (write_data_array) begin
      wr_seen++;
      if (exp_wr.size() == 0) chk("extra_write", write_data_array, 0);
      else begin
        w = exp_wr.pop_front();
        chk("wr_offset", word_offset, w.off);
        chk("wr_data", cache_data, w.data);
        chk("wr_tag", write_tag_array, w.tag);
      end
    end else if (write_tag_array) chk("tag_without_write", write_tag_array, 0);
    for (int k = 3; k > 0; k--) begin
      mv[k] = mv[k-1];
      ma[k] = ma[k-1];
    end
    mv[0] = memory_enable;
    ma[0] = memory_address;
  endtask
  task automatic run_out(input string tag, input int exp_busy);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 16'h0, 1'b0);
      if (!fsm_busy && busy_cnt > 0) break;
    end
    chk(tag, busy_cnt, exp_busy);
    chk("sb_issue_left", exp_addr.size(), 0);
    chk("sb_write_left", exp_wr.size(), 0);
  endtask
  task automatic fill(input logic [15:0] a);
    push_exp(a);
    busy_cnt = 0;
    step(1'b1, a, 1'b0);
    chk("busy_at_accept", fsm_busy, 0);
    run_out("busy_cycles", 12);
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, fsm_busy, 0);
    chk({tag, "_men"}, memory_enable, 0);
    chk({tag, "_wda"}, write_data_array, 0);
    chk({tag, "_wta"}, write_tag_array, 0);
    chk({tag, "_maddr"}, memory_address, 0);
    chk({tag, "_woff"}, word_offset, 0);
  endtask
  initial begin
    for (int k = 0; k < 4; k++) begin
      mv[k] = 1'b0;
      ma[k] = '0;
    end
    #1;
    chk_quiet("reset");
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    fill(16'h1236);
    fill(16'h00AC);
    push_exp(16'h3458);
    push_exp(16'h3458);
    busy_cnt = 0;
    step(1'b1, 16'h3458, 1'b0);
    for (int c = 1; c <= 12; c++) step(c == 3 || c == 12, 16'h4000, 1'b0);
    chk("first_busy_cycles", busy_cnt, 12);
    step(1'b1, 16'h3458, 1'b0);
    chk("gap_busy", fsm_busy, 0);
    busy_cnt = 0;
    step(1'b0, 16'h0, 1'b0);
    chk("refill_busy", fsm_busy, 1);
    run_out("second_busy_cycles", 12);
    push_exp(16'h2468);
    step(1'b1, 16'h2468, 1'b0);
    wr_seen = 0;
    for (int i = 0; i < 20 && wr_seen < 3; i++) step(1'b0, 16'h0, 1'b0);
    chk("pre_reset_writes", wr_seen, 3);
    rst = 1'b1;
    #1;
    chk_quiet("midfill_reset");
    exp_addr.delete();
    exp_wr.delete();
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    wr_base = wr_seen;
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b0);
    chk("tail_writes", wr_seen - wr_base, 0);
    chk("tail_busy", fsm_busy, 0);
    step(1'b0, 16'h0, 1'b1);
    chk("stray_write", write_data_array, 0);
    chk("stray_tag", write_tag_array, 0);
    fill(16'hFFFE);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
